aes_frame_loader: RTL and testbench
===================================

AES_FRAME_LOADER -- requirements
Module: aes_frame_loader

Interface
REQ-001 SHALL have parameter nk, default 8, key length in 32-bit words.
REQ-002 SHALL have parameter nb, default 4, block length in 32-bit words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port byte_in  input  8  serial byte stream carrying the message, then the key.
REQ-006 SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-007 SHALL have port byte_ready  output  1  loader can accept a byte.
REQ-008 SHALL have port abort  input  1  synchronous flush of the current frame.
REQ-009 SHALL have port from_Real_msg  output  32*nb  assembled plaintext, fed to the SPI Master.
REQ-010 SHALL have port from_Real_key  output  32*nk  assembled key, fed to the SPI Master.
REQ-011 SHALL have port frame_valid  output  1  msg/key complete and stable.
REQ-012 SHALL have port frame_ack  input  1  Master has taken the frame.
REQ-013 SHALL have port result_in  input  32*nb  returned cipher, from the Master Sipo_Register.
REQ-014 SHALL have port result_valid  input  1  result_in is valid.
REQ-015 SHALL have port cipher_out  output  32*nb  last captured cipher.
REQ-016 SHALL have port cipher_done  output  1  one-cycle pulse when cipher_out updates.

Function
REQ-017 SHALL implement the states LOAD_MSG, LOAD_KEY, PRESENT and WAIT_RES.
REQ-018 SHALL accept a byte only on a rising edge where byte_valid and byte_ready are both 1.
REQ-019 SHALL drive byte_ready to 1 in LOAD_MSG and LOAD_KEY, and to 0 in all other states.
REQ-020 SHALL shift each byte in at the LSB end of the current register (reg <= {reg[W-9:0], byte_in}), so the first byte ends up in the MSB.
REQ-021 SHALL use one byte counter wide enough to reach 4*nk (6 bits for the defaults); it is cleared on every state change.
REQ-022 SHALL, in LOAD_MSG, move to LOAD_KEY when the 4*nb-th message byte is accepted.
REQ-023 SHALL, in LOAD_KEY, move to PRESENT when the 4*nk-th key byte is accepted.
REQ-024 SHALL assert frame_valid the cycle after the last key byte is accepted, with zero added latency.
REQ-025 SHALL hold frame_valid and both data outputs stable through PRESENT.
REQ-026 SHALL, in PRESENT, move to WAIT_RES and drop frame_valid on the edge where frame_ack is sampled at 1.
REQ-027 SHALL, in WAIT_RES, capture result_in into cipher_out when result_valid is 1, pulse cipher_done for exactly one cycle, and return to LOAD_MSG.
REQ-028 SHALL ignore frame_ack outside PRESENT and result_valid outside WAIT_RES.
REQ-029 SHALL ignore byte_valid while byte_ready is 0; no byte is consumed or lost state-wise.
REQ-030 SHALL, when frame_ack and result_valid are both 1 in PRESENT, act on frame_ack only; the result is not captured that cycle.
REQ-031 SHALL give abort priority over all other inputs: go to LOAD_MSG, clear the counter, clear frame_valid and clear the msg/key registers; cipher_out is retained.
REQ-032 SHALL let the message and key registers wrap-free: the counter never exceeds its terminal count, and the next frame starts from LOAD_MSG.

Reset
REQ-033 SHALL, on rst low, immediately enter LOAD_MSG and clear the counter, from_Real_msg, from_Real_key, cipher_out, frame_valid and cipher_done to 0.
REQ-034 SHALL drive byte_ready to 1 one edge after rst deasserts.
REQ-035 SHALL, on a reset in mid-frame or mid-WAIT_RES, discard the partial frame and any pending result.

Verification
REQ-036 SHALL cover: stream 00,11,..,ff then key 00..1f with continuous valid -> from_Real_msg=00112233445566778899aabbccddeeff, from_Real_key=000102..1f, frame_valid high the cycle after byte 48.
REQ-037 SHALL cover: byte_valid toggling every other cycle -> identical result; byte_ready low in PRESENT while valid is held -> no extra byte is taken.
REQ-038 SHALL cover: frame_ack after 10 cycles, then result_valid with 8ea2b7ca516745bfeafc49904b496089 -> cipher_out equals that value, cipher_done lasts 1 cycle, byte_ready returns to 1.
REQ-039 SHALL cover: abort after 20 bytes -> LOAD_MSG, all-zero outputs, and a following full frame assembles correctly.
REQ-040 SHALL cover: rst pulsed low during WAIT_RES -> all outputs 0 asynchronously, and a later result_valid is ignored.
REQ-041 SHALL cover: frame_ack and result_valid high together in PRESENT -> WAIT_RES entered, cipher_out unchanged.

Source files
------------

// File: rtl/aes_frame_loader.sv
// aes_frame_loader: assembles a serial byte stream (message, then key)
// into wide registers, presents them to the SPI Master as one frame and
// captures the returned cipher block.
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   byte_in/byte_valid     incoming byte stream (message bytes, then key bytes)
//   byte_ready             high while a message or key byte can be accepted
//   abort                  synchronous flush of the frame being built
//   from_Real_msg/_key     assembled plaintext and key
//   frame_valid/frame_ack  frame presentation handshake
//   result_in/result_valid cipher block returned by the Master
//   cipher_out/cipher_done last captured cipher and its one-cycle update pulse
module aes_frame_loader #(
    parameter int nk = 8,
    parameter int nb = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              abort,
    output logic [32*nb-1:0]  from_Real_msg,
    output logic [32*nk-1:0]  from_Real_key,
    output logic              frame_valid,
    input  logic              frame_ack,
    input  logic [32*nb-1:0]  result_in,
    input  logic              result_valid,
    output logic [32*nb-1:0]  cipher_out,
    output logic              cipher_done
);

    localparam int MW  = 32 * nb;
    localparam int KW  = 32 * nk;
    localparam int MAXB = (nk > nb) ? 4 * nk : 4 * nb;
    localparam int CW  = $clog2(MAXB + 1);

    localparam logic [CW-1:0] MSG_LAST = CW'(4 * nb - 1);
    localparam logic [CW-1:0] KEY_LAST = CW'(4 * nk - 1);

    typedef enum logic [1:0] {
        LOAD_MSG,
        LOAD_KEY,
        PRESENT,
        WAIT_RES
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          armed;
    logic          take;
    logic          msg_shift;
    logic          key_shift;
    logic          capture;

    // armed holds byte_ready low until the first edge after reset release.
    assign byte_ready  = armed && (state == LOAD_MSG || state == LOAD_KEY);
    assign take        = byte_valid && byte_ready;
    assign frame_valid = (state == PRESENT);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        msg_shift = 1'b0;
        key_shift = 1'b0;
        capture   = 1'b0;
        if (abort) begin
            state_nx = LOAD_MSG;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                LOAD_MSG: begin
                    if (take) begin
                        msg_shift = 1'b1;
                        if (cnt == MSG_LAST) begin
                            state_nx = LOAD_KEY;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                end
                LOAD_KEY: begin
                    if (take) begin
                        key_shift = 1'b1;
                        if (cnt == KEY_LAST) begin
                            state_nx = PRESENT;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    // frame_ack wins; a coincident result_valid is dropped.
                    if (frame_ack) begin
                        state_nx = WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (result_valid) begin
                        capture  = 1'b1;
                        state_nx = LOAD_MSG;
                    end
                end
                default: begin
                    state_nx = LOAD_MSG;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= LOAD_MSG;
            cnt           <= '0;
            armed         <= 1'b0;
            from_Real_msg <= '0;
            from_Real_key <= '0;
            cipher_out    <= '0;
            cipher_done   <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            armed       <= 1'b1;
            cipher_done <= capture;
            if (abort) begin
                from_Real_msg <= '0;
                from_Real_key <= '0;
            end else begin
                if (msg_shift) begin
                    from_Real_msg <= {from_Real_msg[MW-9:0], byte_in};
                end
                if (key_shift) begin
                    from_Real_key <= {from_Real_key[KW-9:0], byte_in};
                end
            end
            if (capture) begin
                cipher_out <= result_in;
            end
        end
    end

endmodule

// File: tb/tb_aes_frame_loader.sv
// tb_aes_frame_loader: table-driven and randomized self-checking bench
// for aes_frame_loader with a byte-queue reference model.
module tb_aes_frame_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         abort;
    logic [127:0] from_Real_msg;
    logic [255:0] from_Real_key;
    logic         frame_valid;
    logic         frame_ack;
    logic [127:0] result_in;
    logic         result_valid;
    logic [127:0] cipher_out;
    logic         cipher_done;

    aes_frame_loader #(.nk(8), .nb(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .abort         (abort),
        .from_Real_msg (from_Real_msg),
        .from_Real_key (from_Real_key),
        .frame_valid   (frame_valid),
        .frame_ack     (frame_ack),
        .result_in     (result_in),
        .result_valid  (result_valid),
        .cipher_out    (cipher_out),
        .cipher_done   (cipher_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] msg;
        logic [255:0] key;
        int           gap;
        int           ack_dly;
        logic [127:0] res;
        logic [127:0] exp_msg;
        logic [255:0] exp_key;
    } vec_t;

    vec_t         vt[3];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [127:0] last_cipher = '0;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        byte_in    = b;
        byte_valid = 1'b1;
        t = 0;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL byte_ready_timeout: got 0 want 1");
        end
        @(negedge clk);
    endtask

    // gap: 0 continuous, 1 toggle every other cycle, 2 random idles
    task automatic send_bytes(input logic [7:0] q[$], input int n,
                              input int gap);
        for (int i = 0; i < n; i++) begin
            if (i == 47) chk("fv_before_last", 256'(frame_valid), 256'(0));
            send_byte(q[i]);
            if (i == 47) begin
                chk("fv_after_last", 256'(frame_valid), 256'(1));
                chk("rdy_after_last", 256'(byte_ready), 256'(0));
                byte_valid = 1'b0;
            end else if (gap == 1) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end else if (gap == 2) begin
                int g;
                g = $urandom_range(0, 2);
                if (g != 0) begin
                    byte_valid = 1'b0;
                    repeat (g) @(negedge clk);
                end
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic present_and_result(input int dly, input logic [127:0] res,
                                      input logic [127:0] em,
                                      input logic [255:0] ek);
        byte_in    = 8'ha5;
        byte_valid = 1'b1;
        repeat (dly) @(negedge clk);
        chk("present_rdy", 256'(byte_ready), 256'(0));
        chk("present_fv", 256'(frame_valid), 256'(1));
        chk("present_msg", 256'(from_Real_msg), 256'(em));
        chk("present_key", from_Real_key, ek);
        byte_valid = 1'b0;
        frame_ack  = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk("ack_fv", 256'(frame_valid), 256'(0));
        chk("wait_rdy", 256'(byte_ready), 256'(0));
        result_in    = res;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        chk("cipher", 256'(cipher_out), 256'(res));
        chk("done_hi", 256'(cipher_done), 256'(1));
        @(negedge clk);
        chk("done_lo", 256'(cipher_done), 256'(0));
        chk("rdy_back", 256'(byte_ready), 256'(1));
        last_cipher = res;
    endtask

    task automatic to_queue(input logic [127:0] m, input logic [255:0] k,
                            output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(m[127-8*i -: 8]);
        for (int i = 0; i < 32; i++) q.push_back(k[255-8*i -: 8]);
    endtask

    task automatic chk_flushed(input string nm);
        chk({nm, "_msg"}, 256'(from_Real_msg), 256'(0));
        chk({nm, "_key"}, from_Real_key, 256'(0));
        chk({nm, "_fv"}, 256'(frame_valid), 256'(0));
        chk({nm, "_rdy"}, 256'(byte_ready), 256'(1));
        chk({nm, "_cipher"}, 256'(cipher_out), 256'(last_cipher));
    endtask

    initial begin
        logic [7:0]   q[$];
        logic [127:0] em;
        logic [255:0] ek;
        logic [127:0] r;

        vt[0] = '{msg: 128'h00112233445566778899aabbccddeeff,
                  key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  gap: 0, ack_dly: 10,
                  res: 128'h8ea2b7ca516745bfeafc49904b496089,
                  exp_msg: 128'h00112233445566778899aabbccddeeff,
                  exp_key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f};
        vt[1] = vt[0];
        vt[1].gap = 1;
        vt[1].ack_dly = 3;
        vt[1].res = 128'h0123456789abcdeffedcba9876543210;
        vt[2] = '{msg: {16{8'hff}}, key: {8'h80, {30{8'h00}}, 8'h01},
                  gap: 2, ack_dly: 0, res: {16{8'h5a}},
                  exp_msg: 128'hffffffffffffffffffffffffffffffff,
                  exp_key: 256'h8000000000000000000000000000000000000000000000000000000000000001};

        rst          = 1'b0;
        byte_in      = 8'h00;
        byte_valid   = 1'b0;
        abort        = 1'b0;
        frame_ack    = 1'b0;
        result_in    = '0;
        result_valid = 1'b0;
        #1;
        chk("rst_msg", 256'(from_Real_msg), 256'(0));
        chk("rst_key", from_Real_key, 256'(0));
        chk("rst_cipher", 256'(cipher_out), 256'(0));
        chk("rst_fv", 256'(frame_valid), 256'(0));
        chk("rst_done", 256'(cipher_done), 256'(0));
        chk("rst_rdy", 256'(byte_ready), 256'(0));
        @(negedge clk);
        rst = 1'b1;
        chk("rdy_pre_edge", 256'(byte_ready), 256'(0));
        @(negedge clk);
        chk("rdy_post_edge", 256'(byte_ready), 256'(1));

        for (int v = 0; v < 3; v++) begin
            to_queue(vt[v].msg, vt[v].key, q);
            send_bytes(q, 48, vt[v].gap);
            chk("tbl_msg", 256'(from_Real_msg), 256'(vt[v].exp_msg));
            chk("tbl_key", from_Real_key, vt[v].exp_key);
            present_and_result(vt[v].ack_dly, vt[v].res,
                               vt[v].exp_msg, vt[v].exp_key);
        end

        // abort after 20 bytes, with a byte offered on the abort edge
        to_queue(vt[0].msg, vt[0].key, q);
        send_bytes(q, 20, 0);
        byte_in    = 8'h77;
        byte_valid = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        abort      = 1'b0;
        byte_valid = 1'b0;
        chk_flushed("abort");
        send_bytes(q, 48, 0);
        chk("post_abort_msg", 256'(from_Real_msg), 256'(vt[0].exp_msg));
        chk("post_abort_key", from_Real_key, vt[0].exp_key);
        present_and_result(2, vt[0].res, vt[0].exp_msg, vt[0].exp_key);

        // frame_ack and result_valid together in PRESENT
        to_queue(vt[2].msg, vt[2].key, q);
        send_bytes(q, 48, 0);
        frame_ack    = 1'b1;
        result_valid = 1'b1;
        result_in    = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        @(negedge clk);
        frame_ack    = 1'b0;
        result_valid = 1'b0;
        chk("both_fv", 256'(frame_valid), 256'(0));
        chk("both_cipher", 256'(cipher_out), 256'(last_cipher));
        chk("both_done", 256'(cipher_done), 256'(0));
        chk("both_rdy", 256'(byte_ready), 256'(0));
        result_in    = 128'hcafef00dcafef00dcafef00dcafef00d;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        chk("both_cipher2", 256'(cipher_out),
            256'(128'hcafef00dcafef00dcafef00dcafef00d));
        chk("both_done2", 256'(cipher_done), 256'(1));
        last_cipher = 128'hcafef00dcafef00dcafef00dcafef00d;
        @(negedge clk);

        // reset pulsed during WAIT_RES
        to_queue(vt[0].msg, vt[0].key, q);
        send_bytes(q, 48, 0);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        rst = 1'b0;
        #1;
        chk("wrst_msg", 256'(from_Real_msg), 256'(0));
        chk("wrst_key", from_Real_key, 256'(0));
        chk("wrst_cipher", 256'(cipher_out), 256'(0));
        chk("wrst_fv", 256'(frame_valid), 256'(0));
        chk("wrst_rdy", 256'(byte_ready), 256'(0));
        last_cipher = '0;
        @(negedge clk);
        result_in    = vt[0].res;
        result_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        result_valid = 1'b0;
        chk("wrst_ignore_cipher", 256'(cipher_out), 256'(0));
        chk("wrst_ignore_done", 256'(cipher_done), 256'(0));
        chk("wrst_rdy_back", 256'(byte_ready), 256'(1));

        // randomized frames against the byte-queue model
        for (int f = 0; f < 10; f++) begin
            int ab;
            q.delete();
            for (int i = 0; i < 48; i++) q.push_back(8'($urandom));
            ab = $urandom_range(0, 79);
            if (ab < 48) begin
                send_bytes(q, ab, 2);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk_flushed("rnd_abort");
            end else begin
                for (int i = 0; i < 16; i++) em[127-8*i -: 8] = q[i];
                for (int i = 0; i < 32; i++) ek[255-8*i -: 8] = q[16+i];
                r = {$urandom, $urandom, $urandom, $urandom};
                send_bytes(q, 48, 2);
                present_and_result($urandom_range(0, 5), r, em, ek);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
